// File: rtl/uart_tx_phy_if.sv
// Byte handshake between the UART register/FIFO block (master) and the tx PHY (slave).
interface uart_tx_phy_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_phy.sv
// UART transmit PHY: start bit, 8 data bits LSB first, optional even parity
// (UART_TX_PARITY_EN), STOP_BITS stop bits, timed by the shared oversample tick.
module uart_tx_phy #(
    parameter int OVERSAMPLE_RATE = 16,
    parameter int OVERSAMPLE_BITS = 4,
    parameter int STOP_BITS       = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_tick_i,
    uart_tx_phy_if.slave  tx_if,
    output logic          tx_o,
    output logic          tx_busy_o,
    output logic          tx_done_o
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    localparam logic [OVERSAMPLE_BITS-1:0] LAST_TICK = OVERSAMPLE_BITS'(OVERSAMPLE_RATE - 1);
    localparam logic                       LAST_STOP = 1'(STOP_BITS - 1);

    state_e                     state_q, state_d;
    logic [OVERSAMPLE_BITS-1:0] tick_q, tick_d;
    logic [2:0]                 bit_q, bit_d;
    logic                       stop_q, stop_d;
    logic [7:0]                 shift_q, shift_d;
    logic                       tx_q, tx_d;
    logic                       bit_end;
`ifdef UART_TX_PARITY_EN
    logic                       parity_q, parity_d;
`endif

    assign bit_end        = sample_tick_i && (tick_q == LAST_TICK);
    assign tx_if.tx_ready = (state_q == S_IDLE);
    assign tx_busy_o      = (state_q != S_IDLE);
    assign tx_o           = tx_q;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        tx_done_o = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        // Ticks only pace a frame in flight; a tick on the accept edge is still IDLE and ignored.
        if (state_q != S_IDLE && sample_tick_i) begin
            tick_d = bit_end ? '0 : tick_q + OVERSAMPLE_BITS'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_if.tx_valid) begin
                    state_d  = S_START;
                    shift_d  = tx_if.tx_data;
                    tick_d   = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_if.tx_data;
`endif
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    stop_d  = 1'b0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d = parity_q;
                if (bit_end) begin
                    state_d = S_STOP;
                    stop_d  = 1'b0;
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop_q == LAST_STOP) begin
                        state_d   = S_IDLE;
                        tx_done_o = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_phy.sv
// Scoreboard bench for uart_tx_phy: a line monitor decodes frames on tx and
// compares them with bytes queued by the stimulus; directed timing checks alongside.
module tb_uart_tx_phy;
    localparam int OSR = 4;
    localparam int OSB = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLK = FRAME_BITS * OSR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_tick = 1'b0;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;

    uart_tx_phy_if if_a ();
    uart_tx_phy_if if_b ();

    uart_tx_phy #(.OVERSAMPLE_RATE(OSR), .OVERSAMPLE_BITS(OSB), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .sample_tick_i(sample_tick), .tx_if(if_a),
        .tx_o(tx_a), .tx_busy_o(busy_a), .tx_done_o(done_a));

    uart_tx_phy #(.OVERSAMPLE_RATE(OSR), .OVERSAMPLE_BITS(OSB), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .sample_tick_i(sample_tick), .tx_if(if_b),
        .tx_o(tx_b), .tx_busy_o(busy_b), .tx_done_o(done_b));

    always #5 clk = ~clk;

    int cyc = 0;
    int tick_div = 1;
    int tick_phase = 0;
    int bit_clk = OSR;
    int compared = 0;
    int mismatched = 0;
    logic [7:0] sb_q[$];

    int fall_cyc, last_done_a, last_done_b;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    bit mon_busy = 1'b0;
    bit mon_abort;
    logic [7:0] mon_got, mon_exp;
    logic mon_start, mon_stop, mon_par;
    int mon_bc;

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        tick_phase++;
        if (tick_phase >= tick_div) tick_phase = 0;
        sample_tick = (tick_phase == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor for dut_a: centre-samples each bit and checks against the queue head.
    initial forever begin
        @(negedge clk);
        if (!rst && tx_a === 1'b0) begin
            mon_busy  = 1'b1;
            fall_cyc  = cyc;
            mon_abort = 1'b0;
            mon_bc    = bit_clk;
            repeat (mon_bc / 2) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
            mon_start = tx_a;
            for (int i = 0; i < 8; i++) begin
                repeat (mon_bc) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
                mon_got[i] = tx_a;
            end
`ifdef UART_TX_PARITY_EN
            repeat (mon_bc) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
            mon_par = tx_a;
`endif
            repeat (mon_bc) begin @(negedge clk); if (rst) mon_abort = 1'b1; end
            mon_stop = tx_a;
            if (!mon_abort) begin
                if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected no frame", mon_got);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("frame_byte", mon_got, mon_exp);
                    check("start_bit", mon_start, 1'b0);
                    check("stop_bit", mon_stop, 1'b1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", mon_par, ^mon_exp);
`endif
                end
            end
            mon_busy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && done_a === 1'b1) begin
            done_cnt_a++;
            last_done_a = cyc;
            check("done_while_ready", if_a.tx_ready, 1'b0);
        end
        if (!rst && done_b === 1'b1) begin
            done_cnt_b++;
            last_done_b = cyc;
        end
    end

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 5000 && cyc < n; i++) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] b, input bit expect_frame, input bit hold, output int acc);
        if (expect_frame) sb_q.push_back(b);
        if_a.tx_data  = b;
        if_a.tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (if_a.tx_ready === 1'b1) break;
            @(negedge clk);
        end
        check("accept_ready", if_a.tx_ready, 1'b1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) if_a.tx_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy_a && !mon_busy && sb_q.size() == 0) break;
        end
        check("idle_reached", {busy_a, mon_busy, sb_q.size() == 0}, 3'b001);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, d0, low_seen, acc_b;
        logic [11:0] exp_line;

        if_a.tx_valid = 1'b0; if_a.tx_data = 8'h00;
        if_b.tx_valid = 1'b0; if_b.tx_data = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tx", tx_a, 1'b1);
        check("rst_ready", if_a.tx_ready, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_tx_b", tx_b, 1'b1);
        rst = 1'b0;
        low_seen = 0;
        repeat (20) begin @(negedge clk); if (tx_a !== 1'b1) low_seen++; end
        check("idle_line_low_cycles", low_seen, 0);
        check("idle_busy", busy_a, 1'b0);

        // Single frame 0xA5: tx falls 1 clk after accept, done in the last STOP cycle
        send_a(8'hA5, 1'b1, 1'b0, acc);
        wait_idle_a();
        check("a5_fall_latency", fall_cyc - acc, 1);
        check("a5_done_latency", last_done_a - acc, FRAME_CLK - 1);
        check("a5_done_count", done_cnt_a, 1);

        // Back-to-back with tx_valid held; data changes while busy are ignored
        d0 = done_cnt_a;
        send_a(8'h00, 1'b1, 1'b1, acc);
        send_a(8'hFF, 1'b1, 1'b0, acc2);
        if_a.tx_data = 8'h12;
        check("b2b_accept_gap", acc2 - acc, FRAME_CLK + 1);
        wait_idle_a();
        check("b2b_fall_latency", fall_cyc - acc2, 1);
        check("b2b_done_count", done_cnt_a - d0, 2);

        // Slow tick: one tick every 3 clk, 12-clk bits
        tick_div = 3;
        bit_clk  = 3 * OSR;
        @(negedge clk);
        send_a(8'h3C, 1'b1, 1'b0, acc);
        wait_idle_a();
        tick_div = 1;
        bit_clk  = OSR;
        @(negedge clk);

        // Two stop bits on dut_b: directed line samples at bit centres, then ready return
`ifdef UART_TX_PARITY_EN
        exp_line = {1'b0, 2'b11, 1'b0, 8'h81, 1'b0};
`else
        exp_line = {2'b00, 2'b11, 8'h81, 1'b0};
`endif
        if_b.tx_data  = 8'h81;
        if_b.tx_valid = 1'b1;
        check("b_accept_ready", if_b.tx_ready, 1'b1);
        @(posedge clk);
        #1;
        acc_b = cyc;
        if_b.tx_valid = 1'b0;
        if_b.tx_data  = 8'h00;
        for (int k = 0; k <= FRAME_BITS; k++) begin
            wait_cyc(acc_b + 3 + OSR * k);
            check($sformatf("b_line_bit%0d", k), tx_b, exp_line[k]);
        end
        wait_cyc(acc_b + FRAME_CLK + OSR - 1);
        check("b_ready_before_end", if_b.tx_ready, 1'b0);
        wait_cyc(acc_b + FRAME_CLK + OSR);
        check("b_ready_after_stop", if_b.tx_ready, 1'b1);
        check("b_done_count", done_cnt_b, 1);
        check("b_done_latency", last_done_b - acc_b, FRAME_CLK + OSR - 1);

        // Reset during data bit 3: line snaps high, frame dropped, no done
        send_a(8'h99, 1'b0, 1'b0, acc);
        wait_cyc(acc + 18);
        check("mid_busy", busy_a, 1'b1);
        d0 = done_cnt_a;
        rst = 1'b1;
        #1;
        check("mid_rst_tx", tx_a, 1'b1);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_ready", if_a.tx_ready, 1'b1);
        check("mid_rst_done", done_a, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("mid_rst_no_done", done_cnt_a - d0, 0);
        send_a(8'h55, 1'b1, 1'b0, acc);
        wait_idle_a();

        check("total_done_a", done_cnt_a, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
